// File: rtl/post_hash_pe_batch_scheduler.sv
// Batches per-PE hash results that fall in the current window for the reorder crossbar.
// Optional POST_HASH_SCHED_STAT_EN adds batch and stall counters.
module post_hash_pe_batch_scheduler #(
    parameter int NUM_PE  = 4,
    parameter int ISSUE_W = 16,
    parameter int ADDR_W  = 16,
    parameter int META_W  = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_PE-1:0]           pe_valid,
    input  logic [NUM_PE*ADDR_W-1:0]    pe_addr,
    input  logic [NUM_PE-1:0]           pe_history_valid,
    input  logic [NUM_PE*ADDR_W-1:0]    pe_history_addr,
    input  logic [NUM_PE*META_W-1:0]    pe_meta_match_len,
    input  logic [NUM_PE-1:0]           pe_meta_match_can_ext,
    input  logic [NUM_PE-1:0]           pe_delim,
    output logic [NUM_PE-1:0]           pe_ready,
    input  logic                        win_valid,
    input  logic [ADDR_W-1:0]           win_head_addr,
    input  logic [ISSUE_W*8-1:0]        win_data,
    output logic                        win_ready,
    output logic                        output_valid,
    output logic [NUM_PE-1:0]           output_mask,
    output logic [NUM_PE*ADDR_W-1:0]    output_addr,
    output logic [NUM_PE-1:0]           output_history_valid,
    output logic [NUM_PE*ADDR_W-1:0]    output_history_addr,
    output logic [NUM_PE*META_W-1:0]    output_meta_match_len,
    output logic [NUM_PE-1:0]           output_meta_match_can_ext,
    output logic [NUM_PE-1:0]           output_delim,
    output logic [ISSUE_W*8-1:0]        output_data,
    input  logic                        output_ready,
    output logic                        err_stale,
    output logic [31:0]                 stat_batch_cnt,
    output logic [31:0]                 stat_stall_cnt
);

    localparam int WB = $clog2(ISSUE_W);
    localparam int WW = ADDR_W - WB;
    localparam int CW = $clog2(ISSUE_W + NUM_PE + 1);

    typedef enum logic {IDLE, ISSUE} state_t;

    state_t              state;
    logic [WW-1:0]       cur_win;
    logic [WB:0]         pos_cnt;
    logic [ISSUE_W*8-1:0] data_q;

    logic [NUM_PE-1:0]   sel;
    logic [NUM_PE-1:0]   stale;
    logic [CW-1:0]       sel_cnt;
    logic [CW-1:0]       cnt_sum;
    logic                issuing;
    logic                load;
    logic                close;
    logic                over;
    logic                unused_bits;

    assign unused_bits = ^{win_head_addr[WB-1:0], pe_addr};

    always_comb begin
        sel     = '0;
        stale   = '0;
        sel_cnt = '0;
        for (int i = 0; i < NUM_PE; i++) begin
            if (pe_valid[i] && pe_addr[i*ADDR_W+WB +: WW] == cur_win)
                sel[i] = 1'b1;
            if (pe_valid[i] && pe_addr[i*ADDR_W+WB +: WW] < cur_win)
                stale[i] = 1'b1;
            sel_cnt = sel_cnt + CW'(sel[i]);
        end
    end

    assign issuing = (state == ISSUE);
    assign load    = issuing && (!output_valid || output_ready) && |sel;
    assign cnt_sum = CW'(pos_cnt) + sel_cnt;
    // overflow also closes the window; it is flagged as a protocol error
    assign close   = load && (cnt_sum >= CW'(ISSUE_W) || |(sel & pe_delim));
    assign over    = load && (cnt_sum > CW'(ISSUE_W));

    assign pe_ready  = load ? sel : '0;
    assign win_ready = close;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state                     <= IDLE;
            cur_win                   <= '0;
            pos_cnt                   <= '0;
            data_q                    <= '0;
            output_valid              <= 1'b0;
            output_mask               <= '0;
            output_addr               <= '0;
            output_history_valid      <= '0;
            output_history_addr       <= '0;
            output_meta_match_len     <= '0;
            output_meta_match_can_ext <= '0;
            output_delim              <= '0;
            output_data               <= '0;
            err_stale                 <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (win_valid) begin
                        cur_win <= win_head_addr[ADDR_W-1:WB];
                        data_q  <= win_data;
                        pos_cnt <= '0;
                        state   <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (load)
                        pos_cnt <= cnt_sum[WB:0];
                    if (close)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase

            if (load) begin
                output_valid              <= 1'b1;
                output_mask               <= sel;
                output_addr               <= pe_addr;
                output_history_valid      <= pe_history_valid;
                output_history_addr       <= pe_history_addr;
                output_meta_match_len     <= pe_meta_match_len;
                output_meta_match_can_ext <= pe_meta_match_can_ext;
                output_delim              <= pe_delim;
                output_data               <= data_q;
            end else if (output_ready) begin
                output_valid <= 1'b0;
            end

            if ((issuing && |stale) || over)
                err_stale <= 1'b1;
        end
    end

`ifdef POST_HASH_SCHED_STAT_EN
    logic [31:0] batch_q;
    logic [31:0] stall_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            batch_q <= '0;
            stall_q <= '0;
        end else begin
            if (load)
                batch_q <= batch_q + 32'd1;
            if (output_valid && !output_ready)
                stall_q <= stall_q + 32'd1;
        end
    end

    assign stat_batch_cnt = batch_q;
    assign stat_stall_cnt = stall_q;
`else
    assign stat_batch_cnt = '0;
    assign stat_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_post_hash_pe_batch_scheduler.sv
// Directed table-driven bench for post_hash_pe_batch_scheduler (NUM_PE=4, ISSUE_W=16).
// Stat expectations follow POST_HASH_SCHED_STAT_EN.
module tb_post_hash_pe_batch_scheduler;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [3:0]   pe_valid;
    logic [63:0]  pe_addr;
    logic [3:0]   pe_history_valid;
    logic [63:0]  pe_history_addr;
    logic [15:0]  pe_meta_match_len;
    logic [3:0]   pe_meta_match_can_ext;
    logic [3:0]   pe_delim;
    logic [3:0]   pe_ready;
    logic         win_valid;
    logic [15:0]  win_head_addr;
    logic [127:0] win_data;
    logic         win_ready;
    logic         output_valid;
    logic [3:0]   output_mask;
    logic [63:0]  output_addr;
    logic [3:0]   output_history_valid;
    logic [63:0]  output_history_addr;
    logic [15:0]  output_meta_match_len;
    logic [3:0]   output_meta_match_can_ext;
    logic [3:0]   output_delim;
    logic [127:0] output_data;
    logic         output_ready;
    logic         err_stale;
    logic [31:0]  stat_batch_cnt;
    logic [31:0]  stat_stall_cnt;

    int checks = 0;
    int errors = 0;

    localparam logic [127:0] DATA_A = 128'h0f0e0d0c0b0a09080706050403020100;
    localparam logic [127:0] DATA_B = 128'hdeadbeef_cafef00d_01234567_89abcdef;

`ifdef POST_HASH_SCHED_STAT_EN
    localparam bit STAT = 1'b1;
`else
    localparam bit STAT = 1'b0;
`endif

    always #5 clk = ~clk;

    assign pe_history_valid      = pe_valid;
    assign pe_history_addr       = pe_addr | 64'h1000_1000_1000_1000;
    assign pe_meta_match_len     = 16'h4321;
    assign pe_meta_match_can_ext = pe_valid;

    post_hash_pe_batch_scheduler #(
        .NUM_PE(4), .ISSUE_W(16), .ADDR_W(16), .META_W(4)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .pe_valid(pe_valid),
        .pe_addr(pe_addr),
        .pe_history_valid(pe_history_valid),
        .pe_history_addr(pe_history_addr),
        .pe_meta_match_len(pe_meta_match_len),
        .pe_meta_match_can_ext(pe_meta_match_can_ext),
        .pe_delim(pe_delim),
        .pe_ready(pe_ready),
        .win_valid(win_valid),
        .win_head_addr(win_head_addr),
        .win_data(win_data),
        .win_ready(win_ready),
        .output_valid(output_valid),
        .output_mask(output_mask),
        .output_addr(output_addr),
        .output_history_valid(output_history_valid),
        .output_history_addr(output_history_addr),
        .output_meta_match_len(output_meta_match_len),
        .output_meta_match_can_ext(output_meta_match_can_ext),
        .output_delim(output_delim),
        .output_data(output_data),
        .output_ready(output_ready),
        .err_stale(err_stale),
        .stat_batch_cnt(stat_batch_cnt),
        .stat_stall_cnt(stat_stall_cnt)
    );

    typedef struct {
        logic [3:0]  pv;
        logic [63:0] addr;
        logic [3:0]  dl;
        logic        wv;
        logic [15:0] wh;
        logic [3:0]  pr;
        logic        wr;
        logic        ov;
        logic [3:0]  mask;
        logic [3:0]  delim;
        logic        err;
    } vec_t;

    vec_t tbl[21];

    function automatic vec_t mk(
        logic [3:0] pv, logic [15:0] a3, logic [15:0] a2,
        logic [15:0] a1, logic [15:0] a0, logic [3:0] dl,
        logic wv, logic [15:0] wh, logic [3:0] pr, logic wr,
        logic ov, logic [3:0] mask, logic [3:0] delim, logic err);
        vec_t v;
        v.pv = pv; v.addr = {a3, a2, a1, a0}; v.dl = dl;
        v.wv = wv; v.wh = wh; v.pr = pr; v.wr = wr;
        v.ov = ov; v.mask = mask; v.delim = delim; v.err = err;
        return v;
    endfunction

    task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        pe_valid = '0; pe_addr = '0; pe_delim = '0;
        win_valid = 1'b0; win_head_addr = '0; win_data = DATA_A;
        output_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        pe_valid = '0; pe_addr = '0; pe_delim = '0;
        win_valid = 1'b0; win_head_addr = '0; win_data = DATA_A;
        output_ready = 1'b1;

        //            pv     a3     a2     a1     a0     dl wv wh     pr     wr ov mask   dlm    err
        tbl[0]  = mk(4'h0, 16'h0, 16'h0, 16'h0, 16'h0, 4'h0, 1, 16'h40, 4'h0, 0, 0, 4'h0, 4'h0, 0);
        tbl[1]  = mk(4'hf, 16'h43, 16'h42, 16'h41, 16'h40, 4'h0, 0, 16'h0, 4'hf, 0, 1, 4'hf, 4'h0, 0);
        tbl[2]  = mk(4'hf, 16'h47, 16'h46, 16'h45, 16'h44, 4'h0, 0, 16'h0, 4'hf, 0, 1, 4'hf, 4'h0, 0);
        tbl[3]  = mk(4'hf, 16'h4b, 16'h4a, 16'h49, 16'h48, 4'h0, 0, 16'h0, 4'hf, 0, 1, 4'hf, 4'h0, 0);
        tbl[4]  = mk(4'hf, 16'h4f, 16'h4e, 16'h4d, 16'h4c, 4'h0, 0, 16'h0, 4'hf, 1, 1, 4'hf, 4'h0, 0);
        tbl[5]  = mk(4'h0, 16'h0, 16'h0, 16'h0, 16'h0, 4'h0, 0, 16'h0, 4'h0, 0, 0, 4'h0, 4'h0, 0);
        tbl[6]  = mk(4'h1, 16'h0, 16'h0, 16'h0, 16'h40, 4'h0, 0, 16'h0, 4'h0, 0, 0, 4'h0, 4'h0, 0);
        tbl[7]  = mk(4'h3, 16'h0, 16'h0, 16'h52, 16'h45, 4'h0, 1, 16'h40, 4'h0, 0, 0, 4'h0, 4'h0, 0);
        tbl[8]  = mk(4'h3, 16'h0, 16'h0, 16'h52, 16'h45, 4'h0, 1, 16'h50, 4'h1, 0, 1, 4'h1, 4'h0, 0);
        tbl[9]  = mk(4'h3, 16'h0, 16'h0, 16'h52, 16'h46, 4'h1, 1, 16'h50, 4'h1, 1, 1, 4'h1, 4'h1, 0);
        tbl[10] = mk(4'h2, 16'h0, 16'h0, 16'h52, 16'h0, 4'h0, 1, 16'h50, 4'h0, 0, 0, 4'h0, 4'h0, 0);
        tbl[11] = mk(4'h2, 16'h0, 16'h0, 16'h52, 16'h0, 4'h0, 0, 16'h0, 4'h2, 0, 1, 4'h2, 4'h0, 0);
        tbl[12] = mk(4'h1, 16'h0, 16'h0, 16'h0, 16'h53, 4'h1, 0, 16'h0, 4'h1, 1, 1, 4'h1, 4'h1, 0);
        tbl[13] = mk(4'h0, 16'h0, 16'h0, 16'h0, 16'h0, 4'h0, 1, 16'h40, 4'h0, 0, 0, 4'h0, 4'h0, 0);
        tbl[14] = mk(4'hf, 16'h43, 16'h42, 16'h41, 16'h40, 4'h0, 0, 16'h0, 4'hf, 0, 1, 4'hf, 4'h0, 0);
        tbl[15] = mk(4'h7, 16'h0, 16'h46, 16'h45, 16'h44, 4'h0, 0, 16'h0, 4'h7, 0, 1, 4'h7, 4'h0, 0);
        tbl[16] = mk(4'h4, 16'h0, 16'h47, 16'h0, 16'h0, 4'h4, 0, 16'h0, 4'h4, 1, 1, 4'h4, 4'h4, 0);
        tbl[17] = mk(4'h0, 16'h0, 16'h0, 16'h0, 16'h0, 4'h0, 0, 16'h0, 4'h0, 0, 0, 4'h0, 4'h0, 0);
        tbl[18] = mk(4'h8, 16'h30, 16'h0, 16'h0, 16'h0, 4'h0, 1, 16'h40, 4'h0, 0, 0, 4'h0, 4'h0, 0);
        tbl[19] = mk(4'h8, 16'h30, 16'h0, 16'h0, 16'h0, 4'h0, 0, 16'h0, 4'h0, 0, 0, 4'h0, 4'h0, 1);
        tbl[20] = mk(4'h0, 16'h0, 16'h0, 16'h0, 16'h0, 4'h0, 0, 16'h0, 4'h0, 0, 0, 4'h0, 4'h0, 1);

        // reset state
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst output_valid", 128'(output_valid), 128'd0);
        chk("rst output_mask", 128'(output_mask), 128'd0);
        chk("rst output_addr", 128'(output_addr), 128'd0);
        chk("rst output_data", output_data, 128'd0);
        chk("rst pe_ready", 128'(pe_ready), 128'd0);
        chk("rst win_ready", 128'(win_ready), 128'd0);
        chk("rst err_stale", 128'(err_stale), 128'd0);
        chk("rst stat_batch", 128'(stat_batch_cnt), 128'd0);
        chk("rst stat_stall", 128'(stat_stall_cnt), 128'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 21; i++) begin
            @(negedge clk);
            pe_valid = tbl[i].pv;
            pe_addr = tbl[i].addr;
            pe_delim = tbl[i].dl;
            win_valid = tbl[i].wv;
            win_head_addr = tbl[i].wh;
            output_ready = 1'b1;
            #1;
            chk($sformatf("v%0d pe_ready", i), 128'(pe_ready), 128'(tbl[i].pr));
            chk($sformatf("v%0d win_ready", i), 128'(win_ready), 128'(tbl[i].wr));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d output_valid", i), 128'(output_valid), 128'(tbl[i].ov));
            chk($sformatf("v%0d err_stale", i), 128'(err_stale), 128'(tbl[i].err));
            if (tbl[i].ov) begin
                chk($sformatf("v%0d output_mask", i), 128'(output_mask), 128'(tbl[i].mask));
                chk($sformatf("v%0d output_delim", i),
                    128'(output_delim & output_mask), 128'(tbl[i].delim));
                chk($sformatf("v%0d output_data", i), output_data, DATA_A);
            end
        end

        // backpressure with a pending batch
        do_reset();
        #1;
        chk("bp reset clears err", 128'(err_stale), 128'd0);
        @(negedge clk);
        win_valid = 1'b1; win_head_addr = 16'h80; win_data = DATA_B;
        @(negedge clk);
        win_valid = 1'b0; win_data = DATA_A;
        pe_valid = 4'h3; pe_addr = {16'h0, 16'h0, 16'h82, 16'h81};
        #1;
        chk("bp first pe_ready", 128'(pe_ready), 128'h3);
        @(posedge clk);
        #1;
        chk("bp first output_valid", 128'(output_valid), 128'd1);
        @(negedge clk);
        output_ready = 1'b0;
        pe_addr = {16'h0, 16'h0, 16'h84, 16'h83};
        for (int c = 0; c < 5; c++) begin
            #1;
            chk($sformatf("bp%0d pe_ready", c), 128'(pe_ready), 128'd0);
            @(posedge clk);
            #1;
            chk($sformatf("bp%0d output_valid", c), 128'(output_valid), 128'd1);
            chk($sformatf("bp%0d output_mask", c), 128'(output_mask), 128'h3);
            chk($sformatf("bp%0d output_addr", c), 128'(output_addr[31:0]), 128'h0082_0081);
            chk($sformatf("bp%0d hist_addr", c),
                128'(output_history_addr[15:0]), 128'h1081);
            chk($sformatf("bp%0d meta", c), 128'(output_meta_match_len[7:0]), 128'h21);
            chk($sformatf("bp%0d output_data", c), output_data, DATA_B);
            @(negedge clk);
        end
        chk("bp stat_stall", 128'(stat_stall_cnt), STAT ? 128'd5 : 128'd0);
        chk("bp stat_batch", 128'(stat_batch_cnt), STAT ? 128'd1 : 128'd0);
        output_ready = 1'b1;
        #1;
        chk("bp release pe_ready", 128'(pe_ready), 128'h3);
        @(posedge clk);
        #1;
        chk("bp second output_addr", 128'(output_addr[31:0]), 128'h0084_0083);
        chk("bp second stat_batch", 128'(stat_batch_cnt), STAT ? 128'd2 : 128'd0);
        chk("bp second stat_stall", 128'(stat_stall_cnt), STAT ? 128'd5 : 128'd0);

        // reset asserted mid-batch
        @(negedge clk);
        pe_addr = {16'h0, 16'h0, 16'h86, 16'h85};
        rst_n = 1'b0;
        #1;
        chk("mid rst output_valid", 128'(output_valid), 128'd0);
        chk("mid rst output_mask", 128'(output_mask), 128'd0);
        chk("mid rst pe_ready", 128'(pe_ready), 128'd0);
        chk("mid rst win_ready", 128'(win_ready), 128'd0);
        @(posedge clk);
        #1;
        chk("mid rst hold output_valid", 128'(output_valid), 128'd0);
        chk("mid rst stat_batch", 128'(stat_batch_cnt), 128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post rst idle pe_ready", 128'(pe_ready), 128'd0);
        @(posedge clk);
        #1;
        chk("post rst output_valid", 128'(output_valid), 128'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/post_hash_pe_batch_scheduler.md
# post_hash_pe_batch_scheduler

Sequences per-PE hash results into window-aligned batches for the reorder crossbar. Sits between the `NUM_HASH_PE` hash PE result ports plus the window data FIFO and the input of `reorder_crossbar`. It emits only batches whose positions fall in the current `HASH_ISSUE_WIDTH`-byte window, counts the positions consumed, and retires the window on completion or delimiter.

## Interface
Parameters:
- NUM_PE, default `NUM_HASH_PE`: number of hash PE result ports.
- ISSUE_W, default `HASH_ISSUE_WIDTH`: window size in bytes (power of two).
- ADDR_W, default `ADDR_WIDTH`: address width.
- META_W, default `META_MATCH_LEN_WIDTH`: meta match length width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- pe_valid  in  NUM_PE  per-PE result valid.
- pe_addr  in  NUM_PE*ADDR_W  position address.
- pe_history_valid  in  NUM_PE  history hit.
- pe_history_addr  in  NUM_PE*ADDR_W  history address.
- pe_meta_match_len  in  NUM_PE*META_W  meta match length.
- pe_meta_match_can_ext  in  NUM_PE  match extensible.
- pe_delim  in  NUM_PE  last position of stream.
- pe_ready  out  NUM_PE  per-PE accept.
- win_valid  in  1  window data available.
- win_head_addr  in  ADDR_W  window head address (low log2(ISSUE_W) bits zero).
- win_data  in  ISSUE_W*8  window bytes.
- win_ready  out  1  window pop.
- output_valid  out  1  batch valid (to crossbar input_valid).
- output_mask  out  NUM_PE  selected PEs.
- output_addr, output_history_valid, output_history_addr, output_meta_match_len, output_meta_match_can_ext, output_delim  out  per-PE widths as inputs  registered batch fields.
- output_data  out  ISSUE_W*8  current window bytes.
- output_ready  in  1  crossbar accept.
- err_stale  out  1  sticky: PE presented an address below the current window.
- stat_batch_cnt  out  32  batches issued.
- stat_stall_cnt  out  32  cycles with output_valid && !output_ready.

## Operation
- Let WB = log2(ISSUE_W) and win(a) = a[ADDR_W-1:WB].
- Registers: state {IDLE, ISSUE}; cur_win (ADDR_W-WB bits); pos_cnt (WB+1 bits); data_q; output register set.
- IDLE: when win_valid, latch cur_win = win(win_head_addr), data_q = win_data, pos_cnt = 0, then go to ISSUE. win_ready is not asserted here.
- ISSUE:
  - sel[i] = pe_valid[i] && win(pe_addr[i]) == cur_win.
  - load = (!output_valid || output_ready) && |sel.
  - pe_ready[i] = load && sel[i]. PEs with a future window are held (pe_ready=0).
  - On load: the output register captures sel as output_mask, the PE fields, and data_q; pos_cnt += popcount(sel).
  - close = load && (pos_cnt + popcount(sel) == ISSUE_W || |(sel & pe_delim)).
  - On close: win_ready=1 for that cycle, and go to IDLE. This costs one bubble cycle per window.
- If pos_cnt + popcount(sel) would exceed ISSUE_W: truncate nothing, close anyway, set err_stale. This is a protocol error.
- If in ISSUE any pe_valid has win(pe_addr) < cur_win (unsigned), set err_stale sticky. That PE is never accepted.
- The output register holds all fields stable while output_valid && !output_ready.
- output_valid clears on output_ready when there is no new load.

## Timing
- Reset values:
  - state=IDLE; cur_win=0; pos_cnt=0; data_q=0.
  - output_valid=0; all output_* fields=0.
  - pe_ready=0; win_ready=0; err_stale=0; stat counters=0.
- pe_ready and win_ready are combinational from registered state, pe_*, and output_ready. There is no combinational path from pe_* to output_valid.
- Latency: PE accepted at cycle t → output_valid at t+1.
- Throughput: one batch per cycle while output_ready=1.
- Simultaneous close and new win_valid: the next window is latched in the IDLE cycle after close.
- Reset asserted mid-batch: everything returns to reset values immediately. Partially consumed windows are discarded.

## Configuration
- POST_HASH_SCHED_STAT_EN defined: stat_batch_cnt increments on each load; stat_stall_cnt increments each cycle with output_valid && !output_ready. Both counters wrap at 2^32.
- POST_HASH_SCHED_STAT_EN undefined: both stat outputs are tied to 0, and no counter flops are instantiated.

## Test plan
- Full window: ISSUE_W=16, NUM_PE=4, window head 0x40, four rounds of all PEs valid with addrs 0x40–0x4F. Required: four batches with mask 4'b1111, win_ready pulses on the 4th accept, state returns to IDLE.
- Mixed windows: PE0 addr 0x45, PE1 addr 0x52, cur window 0x40. Required: batch mask 4'b0001, pe_ready[1]=0 until window 0x50 is latched.
- Delimiter close: pe_delim on PE2 at addr 0x47 after 7 positions. Required: close and win_ready in that accept cycle, output_delim[2]=1.
- Backpressure: output_ready=0 for 5 cycles with a batch pending. Required: output fields stable, pe_ready=0, stat_stall_cnt=5 (macro on) or 0 (macro off).
- Stale address: cur window 0x40, PE3 valid with addr 0x30. Required: err_stale=1 the next cycle and stays 1, pe_ready[3]=0.
- Reset mid-operation: rst_n low during ISSUE with output_valid=1. Required: output_valid=0 and state IDLE while rst_n is low, with no win_ready.
